// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor updates.
// Each channel emits a 50% square wave plus a one-cycle toggle strobe.
module clock_divider_multi #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 28,
    parameter int DEFAULT_DIV = 100000000
) (
    input  logic                                            clk_in,
    input  logic                                            reset,
    input  logic [CHANNELS-1:0]                             en,
    input  logic                                            sync,
    input  logic                                            div_wr,
    input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0]  div_sel,
    input  logic [CNT_W-1:0]                                div_data,
    output logic [CHANNELS-1:0]                             clk_out,
    output logic [CHANNELS-1:0]                             tick,
    output logic [CHANNELS-1:0]                             div_pending
);

    localparam int SEL_W = $clog2(CHANNELS > 1 ? CHANNELS : 2);
    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] act_q, act_d;
        logic [CNT_W-1:0] shd_q, shd_d;
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             hit;
        logic             term;

        // Out-of-range selects never match any channel index.
        assign hit  = div_wr && (div_data != '0) && (div_sel == SEL_W'(g));
        assign term = (cnt_q == act_q - CNT_W'(1));

        always_comb begin
            cnt_d  = cnt_q;
            act_d  = act_q;
            shd_d  = shd_q;
            pend_d = pend_q;
            clk_d  = clk_q;
            tick_d = 1'b0;
            if (sync) begin
                cnt_d  = '0;
                clk_d  = 1'b0;
                pend_d = 1'b0;
                if (hit) begin
                    act_d = div_data;
                    shd_d = div_data;
                end else if (pend_q) begin
                    act_d = shd_q;
                end
            end else if (!en[g]) begin
                if (hit) begin
                    act_d  = div_data;
                    shd_d  = div_data;
                    cnt_d  = '0;
                    pend_d = 1'b0;
                end
            end else if (term) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
                pend_d = 1'b0;
                // A write in the terminal cycle takes over the next period.
                if (hit) begin
                    act_d = div_data;
                    shd_d = div_data;
                end else if (pend_q) begin
                    act_d = shd_q;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (hit) begin
                    shd_d  = div_data;
                    pend_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_in) begin
            if (!reset) begin
                cnt_q  <= '0;
                act_q  <= DEF;
                shd_q  <= DEF;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                act_q  <= act_d;
                shd_q  <= shd_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

        assign clk_out[g]     = clk_q;
        assign tick[g]        = tick_q;
        assign div_pending[g] = pend_q;
    end

endmodule
